// File: rtl/stream_sink_fifo_if.sv
// Handshake/status bundle for stream_sink_fifo: tagged input word, show-ahead
// output with ready back-pressure, occupancy flags and sticky overflow.
interface stream_sink_fifo_if #(
  parameter int FIFO_WIDTH = 8,
  parameter int ADDR_W     = 3
);
  logic [FIFO_WIDTH:0]   data_i;
  logic [FIFO_WIDTH-1:0] data_o;
  logic                  valid_o;
  logic                  ready_i;
  logic [ADDR_W:0]       count_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  overflow_o;
  logic                  clr_ovf_i;

  modport slave (
    input  data_i, ready_i, clr_ovf_i,
    output data_o, valid_o, count_o, full_o, empty_o, overflow_o
  );

  modport master (
    output data_i, ready_i, clr_ovf_i,
    input  data_o, valid_o, count_o, full_o, empty_o, overflow_o
  );
endinterface

// File: rtl/stream_sink_fifo.sv
// Show-ahead circular FIFO fed by tagged words; every output is a flop, so the
// next head-of-buffer payload is computed ahead of the edge.
module stream_sink_fifo #(
  parameter int FIFO_WIDTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  stream_sink_fifo_if.slave  bus
);

  localparam int unsigned     DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [FIFO_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]       count_q, count_d;
  logic                  full_q, empty_q, valid_q, ovf_q, ovf_d;
  logic [FIFO_WIDTH-1:0] data_q, data_d;
  logic [FIFO_WIDTH-1:0] payload_s;
  logic                  push_s, pop_s, push_acc_s, ovf_evt_s;

  // Next-state for pointers, occupancy, registered head and sticky overflow.
  always_comb begin
    payload_s  = bus.data_i[FIFO_WIDTH-1:0];
    push_s     = bus.data_i[FIFO_WIDTH];
    pop_s      = valid_q & bus.ready_i;
    push_acc_s = push_s & (~full_q | pop_s);
    ovf_evt_s  = push_s & full_q & ~pop_s;

    if (push_acc_s) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_acc_s, pop_s})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase

    // The new head is the word being written when it lands at the next read slot.
    if (count_d == {(ADDR_W + 1){1'b0}}) begin
      data_d = {FIFO_WIDTH{1'b0}};
    end else if (push_acc_s && (wr_ptr_q == rd_ptr_d)) begin
      data_d = payload_s;
    end else begin
      data_d = mem_q[rd_ptr_d];
    end

    if (ovf_evt_s) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= {ADDR_W{1'b0}};
      rd_ptr_q <= {ADDR_W{1'b0}};
      count_q  <= {(ADDR_W + 1){1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      valid_q  <= 1'b0;
      data_q   <= {FIFO_WIDTH{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == {(ADDR_W + 1){1'b0}});
      valid_q  <= (count_d != {(ADDR_W + 1){1'b0}});
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst_n && push_acc_s) begin
      mem_q[wr_ptr_q] <= payload_s;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign bus.data_o     = data_q;
  assign bus.valid_o    = valid_q;
  assign bus.count_o    = count_q;
  assign bus.full_o     = full_q;
  assign bus.empty_o    = empty_q;
  assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_stream_sink_fifo.sv
// Directed bench for stream_sink_fifo: expected payloads queued at stimulus
// time, popped and compared by a monitor whenever a transfer is presented.
module tb_stream_sink_fifo;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [7:0] exp_q [$];

  stream_sink_fifo_if #(.FIFO_WIDTH(8), .ADDR_W(3)) bus ();

  stream_sink_fifo #(.FIFO_WIDTH(8), .ADDR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply inputs, then step one clock edge; outputs are read 1 ns after it.
  task automatic cyc(input logic [8:0] din, input logic rdy, input logic clr);
    bus.data_i    = din;
    bus.ready_i   = rdy;
    bus.clr_ovf_i = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  // Scoreboard monitor: checks every transfer and the idle/valid coupling.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.valid_o !== ~bus.empty_o) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL valid_vs_empty: valid %0b empty %0b", bus.valid_o, bus.empty_o);
      end
      if (!bus.valid_o && bus.data_o !== 8'h00) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL idle_data: got %0h expected 0", bus.data_o);
      end
      if (bus.valid_o && bus.ready_i) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL pop_data: got %0h expected nothing (scoreboard empty)", bus.data_o);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.data_o !== e) begin
            errors = errors + 1;
            $display("FAIL pop_data: got %0h expected %0h", bus.data_o, e);
          end
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    cyc(9'h000, 1'b0, 1'b0);
    cyc(9'h000, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("rst_count", int'(bus.count_o), 0);
    chk("rst_empty", int'(bus.empty_o), 1);
    chk("rst_full", int'(bus.full_o), 0);
    chk("rst_valid", int'(bus.valid_o), 0);
    chk("rst_data", int'(bus.data_o), 0);
    chk("rst_ovf", int'(bus.overflow_o), 0);

    // Single transfer.
    push_exp(8'hA5);
    cyc(9'h1A5, 1'b0, 1'b0);
    chk("single_valid", int'(bus.valid_o), 1);
    chk("single_data", int'(bus.data_o), 8'hA5);
    chk("single_count", int'(bus.count_o), 1);
    cyc(9'h000, 1'b1, 1'b0);
    chk("single_drain_valid", int'(bus.valid_o), 0);
    chk("single_drain_data", int'(bus.data_o), 0);
    chk("single_drain_count", int'(bus.count_o), 0);

    // Fill to full, then one dropped word.
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) push_exp(8'(i));
      cyc({1'b1, 8'(i)}, 1'b0, 1'b0);
      if (i == 7) chk("fill7_full", int'(bus.full_o), 0);
      if (i == 8) chk("fill8_full", int'(bus.full_o), 1);
    end
    chk("ovf_count", int'(bus.count_o), 8);
    chk("ovf_set", int'(bus.overflow_o), 1);
    chk("ovf_head", int'(bus.data_o), 8'h01);
    cyc(9'h000, 1'b0, 1'b1);
    chk("ovf_clr", int'(bus.overflow_o), 0);

    // Push and pop together while full.
    push_exp(8'h55);
    cyc(9'h155, 1'b1, 1'b0);
    chk("fullpp_count", int'(bus.count_o), 8);
    chk("fullpp_full", int'(bus.full_o), 1);
    chk("fullpp_ovf", int'(bus.overflow_o), 0);
    chk("fullpp_head", int'(bus.data_o), 8'h02);
    for (int i = 0; i < 8; i++) cyc(9'h000, 1'b1, 1'b0);
    chk("fullpp_empty", int'(bus.empty_o), 1);

    // Untagged words ignored, then back-pressure holds the head.
    for (int i = 0; i < 3; i++) begin
      cyc(9'h0FF, 1'b0, 1'b0);
      chk("tag_gate_count", int'(bus.count_o), 0);
    end
    push_exp(8'h10);
    cyc(9'h110, 1'b0, 1'b0);
    push_exp(8'h20);
    cyc(9'h120, 1'b0, 1'b0);
    chk("bp_count", int'(bus.count_o), 2);
    for (int i = 0; i < 2; i++) begin
      cyc(9'h000, 1'b0, 1'b0);
      chk("bp_hold_data", int'(bus.data_o), 8'h10);
      chk("bp_hold_count", int'(bus.count_o), 2);
    end
    cyc(9'h000, 1'b1, 1'b0);
    chk("bp_next_head", int'(bus.data_o), 8'h20);
    cyc(9'h000, 1'b1, 1'b0);
    chk("bp_empty", int'(bus.empty_o), 1);

    // Overflow set wins over a coincident clear.
    for (int i = 0; i < 8; i++) begin
      push_exp(8'h30 + 8'(i));
      cyc({1'b1, 8'h30 + 8'(i)}, 1'b0, 1'b0);
    end
    cyc(9'h1EE, 1'b0, 1'b0);
    chk("race_pre_ovf", int'(bus.overflow_o), 1);
    cyc(9'h1AA, 1'b0, 1'b1);
    chk("race_ovf_held", int'(bus.overflow_o), 1);
    chk("race_count", int'(bus.count_o), 8);
    cyc(9'h000, 1'b0, 1'b1);
    chk("race_clr", int'(bus.overflow_o), 0);
    for (int i = 0; i < 8; i++) cyc(9'h000, 1'b1, 1'b0);
    chk("race_drained", int'(bus.empty_o), 1);

    // Twenty streaming push/pop pairs across the pointer wrap.
    push_exp(8'h40);
    cyc(9'h140, 1'b0, 1'b0);
    for (int i = 1; i < 20; i++) begin
      push_exp(8'h40 + 8'(i));
      cyc({1'b1, 8'h40 + 8'(i)}, 1'b1, 1'b0);
      chk("wrap_count", int'(bus.count_o), 1);
    end
    chk("wrap_last_head", int'(bus.data_o), 8'h53);
    cyc(9'h000, 1'b1, 1'b0);
    chk("wrap_empty", int'(bus.empty_o), 1);

    // Mid-run reset with five stored words, overflow set and a concurrent push.
    for (int i = 0; i < 9; i++) begin
      if (i < 8) push_exp(8'h60 + 8'(i));
      cyc({1'b1, 8'h60 + 8'(i)}, 1'b0, 1'b0);
    end
    for (int i = 0; i < 3; i++) cyc(9'h000, 1'b1, 1'b0);
    chk("mid_pre_count", int'(bus.count_o), 5);
    chk("mid_pre_ovf", int'(bus.overflow_o), 1);
    bus.ready_i = 1'b0;
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    cyc(9'h1FF, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("mid_count", int'(bus.count_o), 0);
    chk("mid_valid", int'(bus.valid_o), 0);
    chk("mid_data", int'(bus.data_o), 0);
    chk("mid_ovf", int'(bus.overflow_o), 0);
    chk("mid_full", int'(bus.full_o), 0);
    push_exp(8'h77);
    cyc(9'h177, 1'b0, 1'b0);
    chk("post_rst_data", int'(bus.data_o), 8'h77);
    chk("post_rst_count", int'(bus.count_o), 1);
    cyc(9'h000, 1'b1, 1'b0);
    cyc(9'h000, 1'b0, 1'b0);
    chk("final_empty", int'(bus.empty_o), 1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_sink_fifo.md
STREAM_SINK_FIFO -- requirements
Module: stream_sink_fifo

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 8: payload width; the input word carries FIFO_WIDTH+1 bits.
REQ-002 SHALL have parameter ADDR_W, default 3: buffer depth is 2**ADDR_W entries.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic rises on posedge clk.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port data_i, input, FIFO_WIDTH+1 bits: bit FIFO_WIDTH is the valid tag; bits FIFO_WIDTH-1:0 are the payload.
REQ-006 SHALL have port data_o, output, FIFO_WIDTH bits: head-of-buffer payload.
REQ-007 SHALL have port valid_o, output, 1 bit: data_o holds a valid entry.
REQ-008 SHALL have port ready_i, input, 1 bit: the downstream consumer accepts data_o.
REQ-009 SHALL have port count_o, output, ADDR_W+1 bits: number of stored entries.
REQ-010 SHALL have port full_o, output, 1 bit: count_o equals 2**ADDR_W.
REQ-011 SHALL have port empty_o, output, 1 bit: count_o equals 0.
REQ-012 SHALL have port overflow_o, output, 1 bit: sticky flag for a dropped input word.
REQ-013 SHALL have port clr_ovf_i, input, 1 bit: clears overflow_o.

Function
REQ-014 SHALL define a push as a cycle with data_i[FIFO_WIDTH]=1; the payload is data_i[FIFO_WIDTH-1:0]; a word with tag 0 SHALL be ignored.
REQ-015 SHALL define a pop as a cycle with valid_o=1 and ready_i=1.
REQ-016 SHALL store pushed payloads in arrival order in a circular buffer with separate write and read pointers of ADDR_W bits each.
REQ-017 SHALL wrap each pointer from 2**ADDR_W-1 to 0.
REQ-018 SHALL be show-ahead: data_o equals the entry at the read pointer whenever valid_o=1.
REQ-019 SHALL drive data_o to all zeros when empty.
REQ-020 SHALL drive valid_o equal to the inverse of empty_o.
REQ-021 SHALL provide no bypass path: a push into an empty buffer appears on data_o with valid_o=1 on the cycle after the capturing edge (latency 1).
REQ-022 SHALL register count_o, full_o and empty_o, updating them on the same edge as the pointers.
REQ-023 SHALL update count_o as follows:
- push only: +1
- pop only: -1
- push and pop together: unchanged
REQ-024 SHALL accept a push while full if a pop occurs in the same cycle; the popped entry leaves, the new entry is written, and count_o stays 2**ADDR_W.
REQ-025 SHALL handle a push while full with no pop as follows: the payload is dropped, no pointer or count changes, and overflow_o=1 from the next cycle.
REQ-026 SHALL hold overflow_o until a cycle with clr_ovf_i=1, which clears it on the next edge.
REQ-027 SHALL give set priority to an overflow event that coincides with clr_ovf_i=1: overflow_o stays 1.
REQ-028 SHALL handle a push with simultaneous pop while empty as follows: no pop occurs, since valid_o=0, and the push is stored.
REQ-029 SHALL keep data_o, valid_o and count_o stable while valid_o=1 and ready_i=0, except that count_o increments on a push.

Reset
REQ-030 SHALL, on any posedge clk with rst_n=0, set both pointers to 0, count_o=0, empty_o=1, full_o=0, valid_o=0, data_o=0 and overflow_o=0.
REQ-031 SHALL NOT reset buffer storage contents.
REQ-032 SHALL apply reset in the middle of operation: all stored entries are discarded, and a push on the reset cycle is ignored.
REQ-033 SHALL make the first push after rst_n returns to 1 visible on data_o one cycle later.

Verification
REQ-034 SHALL cover single transfer: FIFO_WIDTH=8; data_i=9'h1A5 for one cycle with ready_i=0 -> next cycle valid_o=1, data_o=8'hA5, count_o=1; then ready_i=1 for one cycle -> valid_o=0, data_o=0, count_o=0.
REQ-035 SHALL cover fill and overflow: pushes of payloads 8'h01..8'h09 on consecutive cycles with ready_i=0 -> full_o=1 after the 8th push; the 9th word is dropped; overflow_o=1; draining yields 01..08 in order.
REQ-036 SHALL cover full with simultaneous push and pop: buffer full holding 01..08, then push 8'h55 with ready_i=1 -> count_o stays 8; drain order is 02..08, then 55; overflow_o stays 0.
REQ-037 SHALL cover tag gating and back-pressure: data_i=9'h0FF for 3 cycles -> count_o stays 0; then pushes of 8'h10 and 8'h20 with ready_i=0 -> data_o holds 10 until ready_i=1.
REQ-038 SHALL cover clear/set race and wrap: overflow_o=1 with clr_ovf_i=1 in the same cycle as a new overflow -> overflow_o stays 1; 20 push/pop pairs across pointer wrap -> data order preserved.
REQ-039 SHALL cover mid-run reset: rst_n=0 for one cycle with count_o=5 and a concurrent push -> next cycle count_o=0, valid_o=0, data_o=0, overflow_o=0.
